// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and width helper for the BCD-to-binary converter.
// Imported by bcd_digit_correct and bcd_to_bin.
package bcd_pkg;

    localparam int DIGIT_W = 4;
    localparam int BCD_MAX = 9;
    localparam int CORR    = 3;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    // ceil(log2(10^digits)): bits needed to hold 10^digits-1
    function automatic int bin_width(input int digits);
        longint p;
        int     w;
        p = 1;
        for (int i = 0; i < digits; i++) begin
            p = p * 10;
        end
        p = p - 1;
        w = 0;
        while (p > 0) begin
            w = w + 1;
            p = p >> 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_digit_correct.sv
// Per-digit correction cell for reverse double-dabble: digit >= 8 gets -3.
// Ports: i_digit (4-bit field after shift), o_digit (corrected field).
module bcd_digit_correct
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [DIGIT_W-1:0] o_digit
);

    localparam logic [DIGIT_W-1:0] W_CORR = DIGIT_W'(CORR);

    // >= 8 is exactly the digit MSB being set
    assign o_digit = i_digit[DIGIT_W-1] ? (i_digit - W_CORR) : i_digit;

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter (reverse double-dabble, 1 bit/cycle).
// Ports: i_clk, i_rst_n (sync, active low), i_in_valid/o_in_ready/i_bcd_in input
//   handshake; o_out_valid/i_out_ready/o_bin_out/o_ovf/o_bad_digit result; o_busy.
// Optional macro BCD_TO_BIN_SAT_EN: saturate o_bin_out to all ones on overflow.
module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int DIGITS = 5,
    parameter int OUT_W  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [4*DIGITS-1:0]   i_bcd_in,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [OUT_W-1:0]      o_bin_out,
    output logic                  o_ovf,
    output logic                  o_bad_digit,
    output logic                  o_busy
);

    localparam int ITER  = bin_width(DIGITS);
    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int SR_W  = BCD_W + ITER;
    localparam int CNT_W = $clog2(ITER + 1);

    localparam logic [DIGIT_W-1:0] W_MAX  = DIGIT_W'(BCD_MAX);
    localparam logic [CNT_W-1:0]   W_LAST = CNT_W'(ITER - 1);

    state_t                r_state;
    logic [SR_W-1:0]       r_sr;
    logic [CNT_W-1:0]      r_cnt;
    logic [OUT_W-1:0]      r_bin;
    logic                  r_ovf;
    logic                  r_bad;
    logic                  r_out_valid;
    logic                  r_busy;
    logic                  r_in_ready;

    logic [SR_W-1:0]       w_shift;
    logic [SR_W-1:0]       w_sr_next;
    logic [ITER-1:0]       w_result;
    logic [OUT_W-1:0]      w_wrap;
    logic [OUT_W-1:0]      w_bin;
    logic                  w_ovf;
    logic [DIGITS-1:0]     w_bad;

    assign w_shift             = r_sr >> 1;
    assign w_sr_next[ITER-1:0] = w_shift[ITER-1:0];

    genvar d;
    generate
        for (d = 0; d < DIGITS; d++) begin : g_dig
            bcd_digit_correct u_corr (
                .i_digit (w_shift[ITER+d*DIGIT_W +: DIGIT_W]),
                .o_digit (w_sr_next[ITER+d*DIGIT_W +: DIGIT_W])
            );
            assign w_bad[d] = i_bcd_in[d*DIGIT_W +: DIGIT_W] > W_MAX;
        end
    endgenerate

    // Result is taken from the final iteration's next-state value
    assign w_result = w_sr_next[ITER-1:0];

    generate
        if (ITER > OUT_W) begin : g_ovf
            assign w_ovf  = |w_result[ITER-1:OUT_W];
            assign w_wrap = w_result[OUT_W-1:0];
        end else begin : g_no_ovf
            assign w_ovf  = 1'b0;
            assign w_wrap = OUT_W'(w_result);
        end
    endgenerate

`ifdef BCD_TO_BIN_SAT_EN
    assign w_bin = w_ovf ? {OUT_W{1'b1}} : w_wrap;
`else
    assign w_bin = w_wrap;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_sr        <= '0;
            r_cnt       <= '0;
            r_bin       <= '0;
            r_ovf       <= 1'b0;
            r_bad       <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (i_in_valid && r_in_ready) begin
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        if (|w_bad) begin
                            r_bad       <= 1'b1;
                            r_bin       <= '0;
                            r_ovf       <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_sr    <= {i_bcd_in, {ITER{1'b0}}};
                            r_cnt   <= '0;
                            r_bad   <= 1'b0;
                            r_state <= CONV;
                        end
                    end
                end
                CONV: begin
                    r_sr  <= w_sr_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == W_LAST) begin
                        r_bin       <= w_bin;
                        r_ovf       <= w_ovf;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_bin_out   = r_bin;
    assign o_ovf       = r_ovf;
    assign o_bad_digit = r_bad;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed self-checking bench for bcd_to_bin (default DIGITS=5, OUT_W=16).
// Expected values are hand-computed decimal-to-hex conversions.
module tb_bcd_to_bin;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [19:0] bcd_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] bin_out;
    logic        ovf;
    logic        bad_digit;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    bcd_to_bin dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_bcd_in    (bcd_in),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_bin_out   (bin_out),
        .o_ovf       (ovf),
        .o_bad_digit (bad_digit),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Drive one operand, return cycles from accept to first out_valid (-1 on timeout)
    task automatic run(input logic [19:0] bcd, output int lat);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        in_valid = 1'b1;
        bcd_in   = bcd;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({in_ready, out_valid, busy, ovf, bad_digit, bin_out} !== {1'b1, 4'b0, 16'h0}) begin
            n_err++;
            $display("FAIL reset: rdy/vld/busy/ovf/bad/bin=%b%b%b%b%b/%h want 10000/0000",
                     in_ready, out_valid, busy, ovf, bad_digit, bin_out);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int lat;
        run(20'h12345, lat);
        n_vec++;
        if (lat !== 18) begin
            n_err++;
            $display("FAIL basic_latency: got %0d want 18", lat);
        end
        n_vec++;
        if ({bin_out, ovf, bad_digit, busy} !== {16'h3039, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL basic_12345: bin/ovf/bad/busy=%h/%b/%b/%b want 3039/0/0/1",
                     bin_out, ovf, bad_digit, busy);
        end
    endtask

    task automatic test_edges;
        int lat;
        run(20'h00000, lat);
        n_vec++;
        if ({bin_out, ovf} !== {16'h0000, 1'b0}) begin
            n_err++;
            $display("FAIL zero: bin/ovf=%h/%b want 0000/0", bin_out, ovf);
        end
        run(20'h65535, lat);
        n_vec++;
        if ({bin_out, ovf} !== {16'hFFFF, 1'b0}) begin
            n_err++;
            $display("FAIL max_fit: bin/ovf=%h/%b want ffff/0", bin_out, ovf);
        end
        run(20'h99999, lat);
`ifdef BCD_TO_BIN_SAT_EN
        n_vec++;
        if ({bin_out, ovf} !== {16'hFFFF, 1'b1}) begin
            n_err++;
            $display("FAIL ovf_sat: bin/ovf=%h/%b want ffff/1", bin_out, ovf);
        end
`else
        n_vec++;
        if ({bin_out, ovf} !== {16'h869F, 1'b1}) begin
            n_err++;
            $display("FAIL ovf_wrap: bin/ovf=%h/%b want 869f/1", bin_out, ovf);
        end
`endif
    endtask

    task automatic test_bad_digit;
        int lat;
        run(20'h1A345, lat);
        n_vec++;
        if (lat !== 1) begin
            n_err++;
            $display("FAIL bad_latency: got %0d want 1", lat);
        end
        n_vec++;
        if ({bad_digit, bin_out, ovf} !== {1'b1, 16'h0, 1'b0}) begin
            n_err++;
            $display("FAIL bad_1A345: bad/bin/ovf=%b/%h/%b want 1/0000/0",
                     bad_digit, bin_out, ovf);
        end
        run(20'hB0000, lat);
        n_vec++;
        if ({lat, bad_digit, bin_out} !== {32'sd1, 1'b1, 16'h0}) begin
            n_err++;
            $display("FAIL bad_top: lat/bad/bin=%0d/%b/%h want 1/1/0000",
                     lat, bad_digit, bin_out);
        end
        run(20'h00250, lat);
        n_vec++;
        if ({bad_digit, bin_out} !== {1'b0, 16'h00FA}) begin
            n_err++;
            $display("FAIL bad_clears: bad/bin=%b/%h want 0/00fa", bad_digit, bin_out);
        end
    endtask

    task automatic test_stall;
        int lat;
        int w;
        run(20'h00250, lat);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            bcd_in   = 20'h11111;
            @(negedge clk);
            n_vec++;
            if ({out_valid, in_ready, bin_out, ovf, bad_digit} !==
                {1'b1, 1'b0, 16'h00FA, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL stall_%0d: vld/rdy/bin/ovf/bad=%b/%b/%h/%b/%b want 1/0/00fa/0/0",
                         i, out_valid, in_ready, bin_out, ovf, bad_digit);
            end
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        bcd_in    = 20'h00007;
        @(negedge clk);
        n_vec++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL stall_take: vld/rdy=%b/%b want 0/1", out_valid, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++;
        if ({busy, in_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL stall_accept: busy/rdy=%b/%b want 1/0", busy, in_ready);
        end
        w = 0;
        while (!out_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        n_vec++;
        if ({out_valid, bin_out} !== {1'b1, 16'h0007}) begin
            n_err++;
            $display("FAIL stall_next: vld/bin=%b/%h want 1/0007", out_valid, bin_out);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        int seen;
        @(negedge clk);
        in_valid = 1'b1;
        bcd_in   = 20'h99999;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_vec++;
        if ({in_ready, out_valid, busy, ovf, bad_digit, bin_out} !== {1'b1, 4'b0, 16'h0}) begin
            n_err++;
            $display("FAIL mid_reset: rdy/vld/busy/ovf/bad/bin=%b%b%b%b%b/%h want 10000/0000",
                     in_ready, out_valid, busy, ovf, bad_digit, bin_out);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid || busy) seen++;
        end
        n_vec++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL mid_reset_quiet: active cycles=%0d want 0", seen);
        end
        run(20'h00042, lat);
        n_vec++;
        if ({lat, bin_out, ovf} !== {32'sd18, 16'h002A, 1'b0}) begin
            n_err++;
            $display("FAIL after_reset: lat/bin/ovf=%0d/%h/%b want 18/002a/0",
                     lat, bin_out, ovf);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        run(20'h00001, lat);
        n_vec++;
        if (bin_out !== 16'h0001) begin
            n_err++;
            $display("FAIL b2b_1: bin=%h want 0001", bin_out);
        end
        run(20'h09999, lat);
        n_vec++;
        if ({lat, bin_out} !== {32'sd18, 16'h270F}) begin
            n_err++;
            $display("FAIL b2b_9999: lat/bin=%0d/%h want 18/270f", lat, bin_out);
        end
        run(20'h40960, lat);
        n_vec++;
        if (bin_out !== 16'hA000) begin
            n_err++;
            $display("FAIL b2b_40960: bin=%h want a000", bin_out);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edges();
        test_bad_digit();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin.md
Name: bcd_to_bin

Overview:
- Sequential converter from packed BCD digits to unsigned binary; the inverse of the display path's binary-to-BCD conversion.
- Uses reverse double-dabble: shift right one bit per cycle, then subtract 3 from every digit that is >= 8.
- Sits between keypad/UART numeric entry and the LCD controller's numeric registers.
- Uses valid/ready handshakes on both sides and converts one operand at a time.

Parameters:
- DIGITS, 5, number of BCD digits accepted; digit 0 is the ones digit in bcd_in[3:0].
- OUT_W, 16, width of bin_out.
- ITER, derived, bits needed to hold 10^DIGITS-1 (17 for DIGITS=5); this is the number of conversion cycles.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  bcd_in is valid.
- in_ready  out  1  block can accept an operand; high only in IDLE.
- bcd_in  in  4*DIGITS  packed BCD operand.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- bin_out  out  OUT_W  binary result.
- ovf  out  1  the true value exceeds 2^OUT_W-1.
- bad_digit  out  1  some input nibble was greater than 9.
- busy  out  1  high in CONV or DONE.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE.
  - bin_out=0, ovf=0, bad_digit=0, out_valid=0, busy=0, in_ready=1.
  - Iteration counter and shift register cleared.
  - Reset wins over every other event; a conversion in flight is discarded with no output.
- States: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - Accept occurs when in_valid && in_ready.
  - On accept with every nibble <= 9: load a shift register {bcd_in, ITER'b0}, clear the counter, go to CONV.
  - On accept with any nibble > 9: go directly to DONE with bad_digit=1, bin_out=0, ovf=0. out_valid appears 1 cycle after accept.
- CONV:
  - One iteration per cycle. Shift the whole register right by 1, then each digit field >= 8 gets -3 (4-bit arithmetic, no borrow between digits).
  - Counter increments each cycle. After iteration ITER, latch results and go to DONE.
  - Result is the low ITER bits of the register.
  - ovf = |result[ITER-1:OUT_W]. bin_out depends on the optional feature.
  - in_valid and bcd_in are ignored; in_ready=0.
- DONE:
  - out_valid=1. bin_out, ovf and bad_digit are held stable while out_ready=0.
  - On out_valid && out_ready, go to IDLE. The same cycle drops out_valid; in_ready rises the next cycle.
  - No bypass: a new operand cannot be accepted in the same cycle a result is taken.
- Latency: out_valid first high ITER+1 cycles after the accept edge (18 for the defaults). Throughput is one conversion per ITER+2 cycles at best.
- Outputs retain their last result in IDLE; only out_valid qualifies them.
- Edge values:
  - An all-zero operand yields 0.
  - A value exactly 2^OUT_W-1 gives ovf=0.
  - DIGITS where ITER <= OUT_W: ovf is constant 0.

Optional Feature:
- Macro: BCD_TO_BIN_SAT_EN.
- Defined: on overflow, bin_out saturates to all ones (0xFFFF); ovf=1.
- Undefined: on overflow, bin_out = result[OUT_W-1:0] (wraps); ovf=1.
- Non-overflow behaviour is identical in both builds.

Decomposition:
- Shared package bcd_pkg:
  - DIGIT_W=4, BCD_MAX=9, CORR=3.
  - Function bin_width(digits) returning ceil(log2(10^digits)).
  - State enum {IDLE, CONV, DONE}.
- One natural sub-module, bcd_digit_correct: a combinational per-digit ">=8 then -3" cell, instantiated DIGITS times in a generate loop.

Test Plan:
- bcd_in=0x12345, out_ready=1 -> bin_out=0x3039, ovf=0, bad_digit=0, out_valid exactly 18 cycles after accept.
- bcd_in=0x00000 and 0x65535 -> bin_out=0x0000 and 0xFFFF, ovf=0 for both.
- bcd_in=0x99999 -> ovf=1; bin_out=0xFFFF with BCD_TO_BIN_SAT_EN, 0x869F without.
- bcd_in=0x1A345 -> bad_digit=1, bin_out=0, out_valid 1 cycle after accept, no CONV cycles.
- out_ready held low 5 cycles in DONE while in_valid toggles -> outputs stable, in_ready=0, no second accept; accept resumes the cycle after out_ready.
- rst_n low at CONV iteration 8 -> next cycle IDLE, out_valid=0, all outputs zero; a subsequent 0x00042 converts to 0x002A.
